score_flash_seq: RTL and testbench



---
 rtl/score_flash_seq.sv | 117 +++++++++++
 tb/tb_score_flash_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_flash_seq.sv
// Flash sequencer for the seven-segment display path: blanks the selected digits
// off/on FLASHES times, pacing each phase with an external FlashTimer.
module score_flash_seq #(
    parameter int FLASHES = 3,
    parameter int DIGITS  = 4
) (
    input  logic              CLK_50MHZ,
    input  logic              RST,
    input  logic              trigger,
    input  logic [DIGITS-1:0] digit_mask,
    output logic              timer_start,
    input  logic              timer_done,
    output logic [DIGITS-1:0] blank,
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OFF_START,
        ST_OFF_WAIT,
        ST_ON_START,
        ST_ON_WAIT
    } state_e;

    localparam logic [3:0] LAST_FLASH = 4'(FLASHES - 1);

    state_e            state_q, state_d;
    logic [DIGITS-1:0] mask_q, mask_d;
    logic [3:0]        flash_cnt_q, flash_cnt_d;
    logic              pend_q, pend_d;
    logic [DIGITS-1:0] pend_mask_q, pend_mask_d;
    logic              timer_start_q, timer_start_d;
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              busy_q, busy_d;
    logic              trig_ok;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        mask_d      = mask_q;
        flash_cnt_d = flash_cnt_q;
        pend_d      = pend_q;
        pend_mask_d = pend_mask_q;
        trig_ok     = trigger && (digit_mask != '0);

        // A retrigger while busy only queues; the last one wins.
        if (state_q != ST_IDLE && trig_ok) begin
            pend_d      = 1'b1;
            pend_mask_d = digit_mask;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (trig_ok) begin
                    mask_d      = digit_mask;
                    flash_cnt_d = '0;
                    state_d     = ST_OFF_START;
                end
            end
            ST_OFF_START: state_d = ST_OFF_WAIT;
            ST_OFF_WAIT: begin
                if (timer_done) state_d = ST_ON_START;
            end
            ST_ON_START: state_d = ST_ON_WAIT;
            ST_ON_WAIT: begin
                if (timer_done) begin
                    if (flash_cnt_q < LAST_FLASH) begin
                        flash_cnt_d = flash_cnt_q + 4'd1;
                        state_d     = ST_OFF_START;
                    end else if (pend_d) begin
                        // pend_d already folds in a trigger arriving on this very cycle.
                        mask_d      = pend_mask_d;
                        pend_d      = 1'b0;
                        flash_cnt_d = '0;
                        state_d     = ST_OFF_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are derived from the next state so they can be registered with no lag.
        timer_start_d = (state_d == ST_OFF_START) || (state_d == ST_ON_START);
        blank_d       = ((state_d == ST_OFF_START) || (state_d == ST_OFF_WAIT)) ? mask_d : '0;
        busy_d        = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            state_q       <= ST_IDLE;
            mask_q        <= '0;
            flash_cnt_q   <= '0;
            pend_q        <= 1'b0;
            pend_mask_q   <= '0;
            timer_start_q <= 1'b0;
            blank_q       <= '0;
            busy_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q       <= state_d;
            mask_q        <= mask_d;
            flash_cnt_q   <= flash_cnt_d;
            pend_q        <= pend_d;
            pend_mask_q   <= pend_mask_d;
            timer_start_q <= timer_start_d;
            blank_q       <= blank_d;
            busy_q        <= busy_d;
        end
    end

    assign timer_start = timer_start_q;
    assign blank       = blank_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_score_flash_seq.sv
// Self-checking bench for score_flash_seq: phase-count reference model, a 7-cycle
// FlashTimer model, directed scenarios and a randomized soak.
module tb_score_flash_seq;

    localparam int FLASHES = 3;
    localparam int DIGITS  = 4;
    localparam int TMR_LAT = 7;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b1;
    logic              trigger    = 1'b0;
    logic [DIGITS-1:0] digit_mask = '0;
    logic              model_done = 1'b0;
    logic              spur_done  = 1'b0;
    logic              timer_done;
    logic              timer_start;
    logic [DIGITS-1:0] blank;
    logic              busy;

    int checks   = 0;
    int errors   = 0;
    int n_starts = 0;
    int tmr_cnt  = 0;
    int base     = 0;

    // Reference model state: phases still to be timed, current and queued masks.
    int                phases_left = 0;
    logic [DIGITS-1:0] cur_mask    = '0;
    logic [DIGITS-1:0] pend_mask_m = '0;
    bit                pend_m      = 1'b0;
    bit                start_m     = 1'b0;

    assign timer_done = model_done | spur_done;

    always #10 clk = ~clk;

    score_flash_seq #(.FLASHES(FLASHES), .DIGITS(DIGITS)) dut (
        .CLK_50MHZ  (clk),
        .RST        (rst_n),
        .trigger    (trigger),
        .digit_mask (digit_mask),
        .timer_start(timer_start),
        .timer_done (timer_done),
        .blank      (blank),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FlashTimer model: done is sampled 7 edges after the edge that registered start.
    initial forever begin
        @(negedge clk);
        model_done = 1'b0;
        if (tmr_cnt > 0) begin
            tmr_cnt--;
            if (tmr_cnt == 0) model_done = 1'b1;
        end
        if (timer_start === 1'b1) tmr_cnt = TMR_LAT - 1;
    end

    initial forever begin
        @(negedge clk);
        if (timer_start === 1'b1) n_starts++;
    end

    // Behavioural model: a sequence is 2*FLASHES timed phases; even phases are dark.
    initial forever begin
        bit trig_ok;
        bit was_start;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            phases_left = 0;
            cur_mask    = '0;
            pend_m      = 1'b0;
            pend_mask_m = '0;
            start_m     = 1'b0;
        end else begin
            trig_ok   = trigger && (digit_mask != '0);
            was_start = start_m;
            start_m   = 1'b0;
            if (phases_left == 0) begin
                if (trig_ok) begin
                    cur_mask    = digit_mask;
                    phases_left = 2 * FLASHES;
                    start_m     = 1'b1;
                end
            end else begin
                if (trig_ok) begin
                    pend_m      = 1'b1;
                    pend_mask_m = digit_mask;
                end
                if (timer_done && !was_start) begin
                    phases_left--;
                    if (phases_left > 0) begin
                        start_m = 1'b1;
                    end else if (pend_m) begin
                        cur_mask    = pend_mask_m;
                        pend_m      = 1'b0;
                        phases_left = 2 * FLASHES;
                        start_m     = 1'b1;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        logic [DIGITS-1:0] exp_blank;
        @(negedge clk);
        exp_blank = (phases_left > 0 && ((2 * FLASHES - phases_left) % 2 == 0)) ? cur_mask : '0;
        check("cyc_busy", 32'(busy), 32'(phases_left > 0));
        check("cyc_start", 32'(timer_start), 32'(start_m));
        check("cyc_blank", 32'(blank), 32'(exp_blank));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_trig(input logic [DIGITS-1:0] m);
        trigger    = 1'b1;
        digit_mask = m;
        @(negedge clk);
        trigger    = 1'b0;
        digit_mask = '0;
    endtask

    task automatic wait_starts(input int n, input int max_cyc);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < max_cyc) begin
            @(negedge clk);
            #1;
            cyc++;
            if (timer_start) seen++;
        end
        check("wait_starts", 32'(seen), 32'(n));
    endtask

    task automatic wait_idle(input int max_cyc);
        int cyc = 0;
        while (busy && cyc < max_cyc) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;

        // Reset state
        #2 rst_n = 1'b0;
        step(2);
        #1;
        check("rst_blank", 32'(blank), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(timer_start), 32'd0);
        rst_n = 1'b1;
        step(3);
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_blank", 32'(blank), 32'd0);

        // Basic sequence
        base = n_starts;
        pulse_trig(4'b0101);
        #1;
        check("basic_start", 32'(timer_start), 32'd1);
        check("basic_blank", 32'(blank), 32'h5);
        check("basic_busy", 32'(busy), 32'd1);
        check("model_phases", 32'(phases_left), 32'd6);
        wait_idle(200);
        check("basic_pulses", 32'(n_starts - base), 32'd6);

        // Zero mask and spurious done in IDLE
        pulse_trig(4'b0000);
        #1;
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_start", 32'(timer_start), 32'd0);
        check("zero_blank", 32'(blank), 32'd0);
        spur_done = 1'b1;
        step(1);
        spur_done = 1'b0;
        step(1);
        #1;
        check("spur_busy", 32'(busy), 32'd0);
        check("spur_start", 32'(timer_start), 32'd0);

        // Queued retrigger: last of two retriggers wins, no idle gap
        base = n_starts;
        pulse_trig(4'b0101);
        wait_starts(2, 100);
        pulse_trig(4'b1000);
        step(2);
        pulse_trig(4'b0010);
        wait_starts(4, 200);
        check("queue_blank", 32'(blank), 32'h2);
        check("queue_start", 32'(timer_start), 32'd1);
        check("queue_busy", 32'(busy), 32'd1);
        wait_idle(300);
        check("queue_pulses", 32'(n_starts - base), 32'd12);

        // Trigger coinciding with the final timer_done
        base = n_starts;
        pulse_trig(4'b0101);
        wait_starts(5, 200);
        cyc = 0;
        while (!timer_done && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("simul_done_seen", 32'(timer_done), 32'd1);
        pulse_trig(4'b1111);
        #1;
        check("simul_blank", 32'(blank), 32'hF);
        check("simul_start", 32'(timer_start), 32'd1);
        check("simul_busy", 32'(busy), 32'd1);
        wait_idle(200);
        check("simul_pulses", 32'(n_starts - base), 32'd12);

        // Reset in OFF_WAIT, stale done ignored, then a fresh sequence
        pulse_trig(4'b0110);
        #1;
        step(1);
        #5 rst_n = 1'b0;
        #1;
        check("midrst_blank", 32'(blank), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_start", 32'(timer_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(12);
        #1;
        check("stale_done_busy", 32'(busy), 32'd0);
        base = n_starts;
        pulse_trig(4'b0001);
        #1;
        check("fresh_blank", 32'(blank), 32'h1);
        wait_idle(200);
        check("fresh_pulses", 32'(n_starts - base), 32'd6);

        // Randomized soak against the model
        repeat (3000) begin
            @(negedge clk);
            trigger    = ($urandom_range(0, 15) == 0);
            digit_mask = 4'($urandom_range(0, 15));
            spur_done  = ($urandom_range(0, 63) == 0);
        end
        @(negedge clk);
        trigger    = 1'b0;
        digit_mask = '0;
        spur_done  = 1'b0;
        wait_idle(500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
